// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types and constants for the load/store unit: FSM state encoding,
// funct3 access-size codes and bus width parameters.
// -----------------------------------------------------------------------------
package lsu_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = XLEN / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane steering for the load/store unit.
//   funct3_i     access size / signedness
//   addr_lo_i    low two address bits (byte offset within the word)
//   is_store_i   access is a store (BU/HU are not valid store sizes)
//   wdata_i      store source register value
//   rdata_i      registered bus read word
//   be_o         byte enables for the access
//   wdata_o      store data replicated across all lanes of its size
//   rdata_o      extracted, sign/zero-extended load value
//   misalign_o   halfword not on a 2-byte boundary, or word not on 4
//   illegal_o    funct3 is not a valid code for this access direction
// -----------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic            is_store_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [BE_W-1:0] be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            misalign_o,
  output logic            illegal_o
);

  logic [XLEN-1:0] shifted;

  // Bring the addressed byte/halfword down to bit 0 before extending.
  assign shifted = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    be_o       = '0;
    wdata_o    = '0;
    rdata_o    = '0;
    misalign_o = 1'b0;
    illegal_o  = 1'b0;
    unique case (funct3_i)
      F3_B, F3_BU: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = (funct3_i == F3_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                     : {24'd0, shifted[7:0]};
        illegal_o = is_store_i && (funct3_i == F3_BU);
      end
      F3_H, F3_HU: begin
        be_o       = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = (funct3_i == F3_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                        : {16'd0, shifted[15:0]};
        misalign_o = addr_lo_i[0];
        illegal_o  = is_store_i && (funct3_i == F3_HU);
      end
      F3_W: begin
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        rdata_o    = shifted;
        misalign_o = (addr_lo_i != 2'b00);
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Multi-cycle data-memory access unit. Runs one request/ready/rvalid bus
// transaction per load/store, holding the datapath via stall until DONE.
//   clk, rst        clock; synchronous active-high reset
//   MemRead/Write   current instruction is a load/store (store wins)
//   ALUResult       byte address;  WriteData  store source value
//   Funct3          access size code
//   ReadData        extended load value, nonzero only in DONE
//   stall           hold the datapath while an access is outstanding
//   fault           one-cycle pulse on misalign, illegal funct3, timeout
//   mem_*           wait-stated data-memory bus
// -----------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [XLEN-1:0] ALUResult,
  input  logic [XLEN-1:0] WriteData,
  input  logic [2:0]      Funct3,
  output logic [XLEN-1:0] ReadData,
  output logic            stall,
  output logic            fault,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [BE_W-1:0] mem_be,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic            mem_req_q, mem_we_q, fault_q;
  logic [BE_W-1:0] mem_be_q;
  logic [XLEN-1:0] mem_wdata_q, rdata_q;

  logic            mem_op, timeout_hit;
  logic [BE_W-1:0] al_be;
  logic [XLEN-1:0] al_wdata, al_rdata;
  logic            al_misalign, al_illegal;

  lsu_align u_align (
    .funct3_i   (Funct3),
    .addr_lo_i  (ALUResult[1:0]),
    .is_store_i (MemWrite),
    .wdata_i    (WriteData),
    .rdata_i    (rdata_q),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata),
    .misalign_o (al_misalign),
    .illegal_o  (al_illegal)
  );

  assign mem_op      = MemRead | MemWrite;
  // Counter starts at 0 on the first REQ cycle, so TIMEOUT-1 marks the
  // last permitted REQ/WAIT cycle.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  assign stall     = mem_op && (state_q != S_DONE);
  assign fault     = fault_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_addr  = {ALUResult[XLEN-1:2], 2'b00};
  assign ReadData  = (state_q == S_DONE) ? al_rdata : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: rdata_q is a single word register, so it is reset along with
      // the rest; a late rvalid after reset must not leave stale data.
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      fault_q     <= 1'b0;
    end else begin
      fault_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (mem_op) begin
            rdata_q <= '0;
            if (al_misalign || al_illegal) begin
              fault_q <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q     <= S_REQ;
              cnt_q       <= '0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= MemWrite;
              mem_be_q    <= al_be;
              mem_wdata_q <= MemWrite ? al_wdata : '0;
            end
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // An accept on the final permitted cycle still completes.
          if (mem_ready || timeout_hit) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            if (!mem_ready) begin
              fault_q <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= mem_we_q ? S_DONE : S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (mem_rvalid) begin
            rdata_q <= mem_rdata;
            state_q <= S_DONE;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            fault_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access unit between the single-cycle datapath and a wait-stated data-memory bus. It takes the address (ALUResult), store data (WriteData), MemWrite/MemRead and funct3 from the current instruction. It runs a request/ready/rvalid bus transaction with byte-lane steering, and holds the datapath via `stall` until the access completes. It returns the aligned, sign- or zero-extended load value on `ReadData`.

## Interface
- `TIMEOUT`, 255: max cycles spent in REQ+WAIT before the access is aborted with a fault.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `MemRead`  in  1  current instruction is a load.
- `MemWrite`  in  1  current instruction is a store; wins if both are high.
- `ALUResult`  in  32  byte address.
- `WriteData`  in  32  store source register value.
- `Funct3`  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; others are illegal.
- `ReadData`  out  32  extended load data, valid in DONE; 0 otherwise.
- `stall`  out  1  combinational: (MemRead|MemWrite) && state!=DONE.
- `fault`  out  1  one-cycle pulse on misalign, illegal funct3 or timeout.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word address, {ALUResult[31:2],2'b00}.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_be`  out  4  byte enables.
- `mem_ready`  in  1  request accepted when mem_req&&mem_ready.
- `mem_rvalid`  in  1  read data valid; only sampled in WAIT.
- `mem_rdata`  in  32  read data.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - No memory op: stay in IDLE, stall=0.
  - Memory op, legal and aligned: go to REQ.
  - Misaligned (H: addr[0]!=0; W: addr[1:0]!=0) or illegal funct3: pulse fault, go to DONE with no bus activity; ReadData=0 and the store is dropped.
- REQ:
  - mem_req=1; addr, we, wdata and be held stable.
  - On accept: store goes to DONE, load goes to WAIT.
- WAIT: on mem_rvalid, register mem_rdata into rdata_q and go to DONE.
- DONE: stall=0, so the register file writes and the PC advances this edge; next state is IDLE unconditionally.
- Timeout:
  - Counter is cleared on entering REQ and increments each cycle in REQ or WAIT.
  - Reaching TIMEOUT: pulse fault, drop mem_req, go to DONE with rdata_q=0.
  - A late mem_rvalid is ignored.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{WriteData[7:0]}}.
  - SH: be=4'b0011<<{addr[1],1'b0}, wdata={2{WriteData[15:0]}}.
  - SW: be=4'b1111, wdata=WriteData.
- Load extract: shift rdata_q right by addr[1:0]*8, then:
  - B/H: sign-extend from bit 7/15.
  - BU/HU: zero-extend.
  - W: pass through.
- Address and funct3 are taken from the live inputs in every state; the datapath keeps them stable while stalled.

## Timing
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_be=0, mem_wdata=0, rdata_q=0, fault=0, timeout counter=0. stall follows its equation (1 if an op is present).
- Minimum latency, ready and rvalid each arriving on their first eligible cycle:
  - Load: 4 cycles (IDLE, REQ, WAIT, DONE); stall high for 3.
  - Store: 3 cycles; stall high for 2.
  - Fault in IDLE: 2 cycles.
- mem_rvalid is never accepted in the same cycle as the request accept; it is at least one cycle later.
- Reset mid-transaction: next edge returns to IDLE and deasserts mem_req; an outstanding rvalid arriving later is ignored.
- Back-to-back memory instructions: a DONE→IDLE cycle always separates them, and the second starts its IDLE cycle stalled.

## Structure
- Package `lsu_pkg`:
  - State enum.
  - Funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - Width localparams.
- Sub-module `lsu_align`: purely combinational.
  - Inputs: Funct3, addr[1:0], WriteData, rdata_q.
  - Outputs: mem_be, mem_wdata, ReadData, misalign/illegal flags.
- FSM and timeout counter stay in the top module.

## Test plan
- LW from 0x100, mem_ready=1 and mem_rvalid=1 immediately, rdata 0xDEADBEEF: stall high 3 cycles, then ReadData=0xDEADBEEF in DONE.
- LB at 0x203, rdata 0x80123456: be unused; ReadData=0xFFFFFF80. LBU at the same address: ReadData=0x00000080.
- SH of 0x1234ABCD to 0x302, mem_ready held low for 5 cycles: mem_req stable for 6 cycles, mem_be=4'b1100, mem_wdata=0xABCDABCD, mem_addr=0x300.
- LW to 0x101: fault pulses once, mem_req never asserts, ReadData=0, stall high for exactly 1 cycle. Funct3=011 gives the same response.
- TIMEOUT=8 with mem_ready never asserted: fault pulse after 8 REQ cycles, mem_req drops, DONE with ReadData=0.
- rst asserted while in WAIT, then mem_rvalid pulsed the following cycle: state is IDLE, rdata_q=0, no fault, and no state change from the rvalid.
